rv_lsu_ctrl: RTL and testbench

- Load/store sequencer between the MEM pipeline stage and the 64-bit doubleword-addressed data memory port.
- Accepts one load/store at a time and checks alignment and funct3 legality.
- Drives the byte-lane strobe, lane-replicated write data and req/gnt/rvalid handshake.
- Stalls the pipeline until the response returns, then delivers the sign- or zero-extended load result.

---
 rtl/rv_lsu_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_rv_lsu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a 64-bit doubleword data port.
// Optional bus timeout fault enabled by defining RV_LSU_TIMEOUT_EN.
module rv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic        lsu_ready_o,
  output logic        lsu_stall_o,
  output logic [63:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_strb_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_f3;
  logic [2:0]  r_off;
  logic        r_we;
  logic [7:0]  r_strb;
  logic [63:0] r_wdata;
  logic [60:0] r_addr;
  logic [63:0] r_rdata;
  logic        r_ready, r_fault, r_misalign, r_rvalid;

  logic        w_illegal, w_misal, w_tout;
  logic        w_latch, w_ready_d, w_fault_d, w_mis_d, w_rv_d;
  logic [7:0]  w_strb;
  logic [63:0] w_wrep;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_w;
  logic [63:0] w_ext;

  assign w_illegal = lsu_we_i ? funct3_i[2] : (funct3_i == 3'b111);

  always_comb begin
    w_misal = 1'b0;
    w_strb  = 8'hFF;
    w_wrep  = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        w_strb = 8'b0000_0001 << addr_i[2:0];
        w_wrep = {8{wdata_i[7:0]}};
      end
      2'b01: begin
        w_misal = addr_i[0];
        w_strb  = 8'b0000_0011 << {addr_i[2:1], 1'b0};
        w_wrep  = {4{wdata_i[15:0]}};
      end
      2'b10: begin
        w_misal = |addr_i[1:0];
        w_strb  = 8'h0F << {addr_i[2], 2'b00};
        w_wrep  = {2{wdata_i[31:0]}};
      end
      default: begin
        w_misal = |addr_i[2:0];
        w_strb  = 8'hFF;
        w_wrep  = wdata_i;
      end
    endcase
  end

  // Lane extraction uses the offset latched at acceptance, not the live address.
  assign w_b = mem_rdata_i[{r_off, 3'b000} +: 8];
  assign w_h = mem_rdata_i[{r_off[2:1], 4'b0000} +: 16];
  assign w_w = mem_rdata_i[{r_off[2], 5'b00000} +: 32];

  always_comb begin
    w_ext = mem_rdata_i;
    unique case (r_f3[1:0])
      2'b00:   w_ext = {{56{~r_f3[2] & w_b[7]}}, w_b};
      2'b01:   w_ext = {{48{~r_f3[2] & w_h[15]}}, w_h};
      2'b10:   w_ext = {{32{~r_f3[2] & w_w[31]}}, w_w};
      default: w_ext = mem_rdata_i;
    endcase
  end

`ifdef RV_LSU_TIMEOUT_EN
  logic [7:0] r_cnt;

  assign w_tout = (r_state != S_IDLE) && (r_cnt == 8'(TIMEOUT_CYC));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_latch) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  // No timeout in this build; the parameter only keeps the interface uniform.
  assign w_tout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_ready_d = 1'b0;
    w_fault_d = 1'b0;
    w_mis_d   = 1'b0;
    w_rv_d    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A request is not re-evaluated during the cycle its retire pulse is shown.
        if (lsu_valid_i && !r_ready) begin
          if (w_illegal) begin
            w_ready_d = 1'b1;
            w_fault_d = 1'b1;
          end else if (w_misal) begin
            w_ready_d = 1'b1;
            w_mis_d   = 1'b1;
          end else begin
            w_latch = 1'b1;
            w_next  = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (w_tout) begin
          w_next    = S_IDLE;
          w_ready_d = 1'b1;
          w_fault_d = 1'b1;
        end else if (mem_gnt_i) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_next    = S_IDLE;
          w_ready_d = 1'b1;
          if (mem_err_i) begin
            w_fault_d = 1'b1;
          end else if (!r_we) begin
            w_rv_d = 1'b1;
          end
        end else if (w_tout) begin
          w_next    = S_IDLE;
          w_ready_d = 1'b1;
          w_fault_d = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_f3       <= '0;
      r_off      <= '0;
      r_we       <= 1'b0;
      r_strb     <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
      r_misalign <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready    <= w_ready_d;
      r_fault    <= w_fault_d;
      r_misalign <= w_mis_d;
      r_rvalid   <= w_rv_d;
      if (w_latch) begin
        r_f3    <= funct3_i;
        r_off   <= addr_i[2:0];
        r_we    <= lsu_we_i;
        r_strb  <= w_strb;
        r_wdata <= w_wrep;
        r_addr  <= addr_i[63:3];
      end
      if (w_rv_d) begin
        r_rdata <= w_ext;
      end
    end
  end

  assign lsu_ready_o   = r_ready;
  assign lsu_stall_o   = lsu_valid_i & ~r_ready;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rvalid;
  assign misalign_o    = r_misalign;
  assign fault_o       = r_fault;
  assign mem_req_o     = (r_state == S_REQ) & ~w_tout;
  assign mem_we_o      = r_we;
  assign mem_addr_o    = {3'b000, r_addr};
  assign mem_strb_o    = r_strb;
  assign mem_wdata_o   = r_wdata;

endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// Self-checking bench for rv_lsu_ctrl: fixed vector table, hand sequences, random ops vs model.
module tb_rv_lsu_ctrl;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrd;
    logic        err;
    int          gd;
    int          rd;
    int          kind;   // 0 legal, 1 misaligned, 2 illegal
    logic [7:0]  strb;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic        rv;
    logic [63:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0, lsu_we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        lsu_ready, lsu_stall, rdata_valid, misalign, fault, mem_req, mem_we;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_strb;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_rdata = '0;

  always #5 clk = ~clk;

  rv_lsu_ctrl #(.TIMEOUT_CYC(255)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .lsu_valid_i(lsu_valid), .lsu_we_i(lsu_we),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .lsu_ready_o(lsu_ready), .lsu_stall_o(lsu_stall), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .misalign_o(misalign), .fault_o(fault),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_strb_o(mem_strb), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err)
  );

`ifdef RV_LSU_TIMEOUT_EN
  logic        t_ready, t_stall, t_rvalid, t_mis, t_fault, t_req, t_we;
  logic [63:0] t_rdata, t_addr, t_wdata;
  logic [7:0]  t_strb;

  rv_lsu_ctrl #(.TIMEOUT_CYC(4)) u_dut_to (
    .clk_i(clk), .rst_n_i(rst_n), .lsu_valid_i(lsu_valid), .lsu_we_i(lsu_we),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .lsu_ready_o(t_ready), .lsu_stall_o(t_stall), .rdata_o(t_rdata),
    .rdata_valid_o(t_rvalid), .misalign_o(t_mis), .fault_o(t_fault),
    .mem_req_o(t_req), .mem_we_o(t_we), .mem_addr_o(t_addr),
    .mem_strb_o(t_strb), .mem_wdata_o(t_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err)
  );
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [63:0] a,
                               input logic [63:0] wd, input logic [63:0] mrd, input logic err,
                               input int gd, input int rd, input int kind, input logic [7:0] strb,
                               input logic [63:0] maddr, input logic [63:0] mwd,
                               input logic rv, input logic [63:0] rdat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd; v.err = err;
    v.gd = gd; v.rd = rd; v.kind = kind; v.strb = strb; v.maddr = maddr;
    v.mwdata = mwd; v.rv = rv; v.rdata = rdat;
    return v;
  endfunction

  // Reference: access size in bytes, byte offset, and plain shift/mask arithmetic.
  function automatic vec_t model(input vec_t vi);
    vec_t        v;
    int unsigned sz, off, s;
    logic [63:0] lane, mask;
    v   = vi;
    sz  = 1 << vi.f3[1:0];
    off = int'(vi.addr % 8);
    if (vi.we ? (vi.f3 >= 4) : (vi.f3 == 7)) v.kind = 2;
    else if ((off % sz) != 0)                v.kind = 1;
    else                                     v.kind = 0;
    s      = ((1 << sz) - 1) << off;
    v.strb = 8'(s);
    v.maddr = vi.addr / 8;
    for (int k = 0; k < 8; k++)
      v.mwdata[8*k +: 8] = vi.wdata[8*(k % int'(sz)) +: 8];
    mask = (sz == 8) ? '1 : ((64'd1 << (8*sz)) - 64'd1);
    lane = (vi.mrd >> (8*off)) & mask;
    if (!vi.f3[2] && sz < 8 && lane[8*sz-1]) lane = lane | ~mask;
    v.rdata = lane;
    v.rv    = !vi.we && !vi.err && v.kind == 0;
    return v;
  endfunction

  // Entered and left at a falling edge with the DUT idle and no pulse showing.
  task automatic apply(input vec_t v);
    lsu_valid = 1'b1; lsu_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    if (v.kind != 0) begin
      chk("early_ready", lsu_ready, 1'b1);
      chk("misalign", misalign, v.kind == 1);
      chk("fault_illegal", fault, v.kind == 2);
      chk("early_no_req", mem_req, 1'b0);
      chk("early_no_rvalid", rdata_valid, 1'b0);
      chk("early_stall", lsu_stall, 1'b0);
      chk("early_rdata_hold", rdata, last_rdata);
      lsu_valid = 1'b0;
      @(negedge clk);
      chk("early_pulse_end", {lsu_ready, misalign, fault}, 3'b000);
      return;
    end
    chk("req_asserted", mem_req, 1'b1);
    chk("strb", mem_strb, v.strb);
    chk("mem_addr", mem_addr, v.maddr);
    chk("mem_we", mem_we, v.we);
    chk("mem_wdata", mem_wdata, v.mwdata);
    chk("stall_busy", lsu_stall, 1'b1);
    chk("no_ready_req", lsu_ready, 1'b0);
    // Scramble live inputs: the request must stay on latched values.
    lsu_we = ~v.we; funct3 = ~v.f3; addr = ~v.addr; wdata = ~v.wdata;
    for (int i = 0; i < v.gd; i++) begin
      mem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req_held", mem_req, 1'b1);
      chk("strb_held", mem_strb, v.strb);
      chk("addr_held", mem_addr, v.maddr);
      chk("wdata_held", mem_wdata, v.mwdata);
      chk("no_ready_stray", lsu_ready, 1'b0);
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("req_dropped", mem_req, 1'b0);
    chk("no_ready_wait", lsu_ready, 1'b0);
    for (int i = 0; i < v.rd; i++) begin
      @(negedge clk);
      chk("wait_idle_req", mem_req, 1'b0);
      chk("wait_no_ready", lsu_ready, 1'b0);
    end
    mem_rvalid = 1'b1; mem_rdata = v.mrd; mem_err = v.err;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = {$urandom, $urandom};
    chk("ready_pulse", lsu_ready, 1'b1);
    chk("fault_resp", fault, v.err);
    chk("rdata_valid", rdata_valid, v.rv);
    chk("no_misalign", misalign, 1'b0);
    chk("stall_released", lsu_stall, 1'b0);
    if (v.rv) last_rdata = v.rdata;
    chk("rdata", rdata, last_rdata);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("pulse_end", {lsu_ready, rdata_valid, fault}, 3'b000);
    chk("rdata_holds", rdata, last_rdata);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
  endtask

  initial begin
    vec_t        tbl[15];
    vec_t        v;
    int unsigned sz;
    logic [2:0]  m;

    tbl[0]  = mkv(0, 3'b000, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0, 0, 0,
                  8'h20, 64'h200, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF80);
    tbl[1]  = mkv(0, 3'b101, 64'h106, 64'h0, 64'hBEEF_0000_0000_0000, 0, 1, 1, 0,
                  8'hC0, 64'h20, 64'h0, 1, 64'h0000_0000_0000_BEEF);
    tbl[2]  = mkv(1, 3'b010, 64'h14, 64'h1234_5678, 64'h0, 0, 3, 0, 0,
                  8'hF0, 64'h2, 64'h1234_5678_1234_5678, 0, 64'h0);
    tbl[3]  = mkv(0, 3'b011, 64'h104, 64'h0, 64'h0, 0, 0, 0, 1, 8'h0, 64'h0, 64'h0, 0, 64'h0);
    tbl[4]  = mkv(1, 3'b100, 64'h200, 64'h0, 64'h0, 0, 0, 0, 2, 8'h0, 64'h0, 64'h0, 0, 64'h0);
    tbl[5]  = mkv(0, 3'b010, 64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 2, 0,
                  8'h0F, 64'h1, 64'h0, 0, 64'h0);
    tbl[6]  = mkv(0, 3'b111, 64'h0, 64'h0, 64'h0, 0, 0, 0, 2, 8'h0, 64'h0, 64'h0, 0, 64'h0);
    tbl[7]  = mkv(0, 3'b010, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0, 0,
                  8'hF0, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_8765_4321);
    tbl[8]  = mkv(1, 3'b001, 64'h2, 64'hABCD, 64'h0, 0, 1, 0, 0,
                  8'h0C, 64'h0, 64'hABCD_ABCD_ABCD_ABCD, 0, 64'h0);
    tbl[9]  = mkv(1, 3'b000, 64'h7, 64'hFFFF_FF5A, 64'h0, 0, 0, 0, 0,
                  8'h80, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 0, 64'h0);
    tbl[10] = mkv(1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 1, 0,
                  8'hFF, 64'h3, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
    tbl[11] = mkv(0, 3'b110, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 0, 2, 0, 0,
                  8'hF0, 64'h0, 64'h0, 1, 64'h0000_0000_8765_4321);
    tbl[12] = mkv(0, 3'b001, 64'h3, 64'h0, 64'h0, 0, 0, 0, 1, 8'h0, 64'h0, 64'h0, 0, 64'h0);
    tbl[13] = mkv(0, 3'b100, 64'h0, 64'h0, 64'h1111_1111_1111_11FF, 0, 0, 0, 0,
                  8'h01, 64'h0, 64'h0, 1, 64'h0000_0000_0000_00FF);
    tbl[14] = mkv(0, 3'b011, 64'h10, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 1, 0,
                  8'hFF, 64'h2, 64'h0, 1, 64'hDEAD_BEEF_CAFE_F00D);

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", lsu_ready, 1'b0);
    chk("rst_stall", lsu_stall, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_rvalid", rdata_valid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_strb", mem_strb, 8'h0);
    chk("rst_wdata", mem_wdata, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 15; i++) apply(tbl[i]);

    // Reset while waiting for the response: everything clears, late rvalid is ignored.
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 64'h24;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("wrst_req", mem_req, 1'b0);
    chk("wrst_strb", mem_strb, 8'h0);
    chk("wrst_addr", mem_addr, 64'h0);
    chk("wrst_rdata", rdata, 64'h0);
    chk("wrst_pulses", {lsu_ready, rdata_valid, fault, misalign}, 4'b0000);
    lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("wrst_stray_ignored", {lsu_ready, rdata_valid, fault}, 3'b000);
    chk("wrst_req_idle", mem_req, 1'b0);

    for (int unsigned n = 0; n < 200; n++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = {$urandom, $urandom};
      sz      = 1 << v.f3[1:0];
      m       = 3'(sz - 1);
      if ($urandom_range(0, 3) != 0) v.addr[2:0] = v.addr[2:0] & ~m;
      v.wdata = {$urandom, $urandom};
      v.mrd   = {$urandom, $urandom};
      v.err   = ($urandom_range(0, 7) == 0);
      v.gd    = int'($urandom_range(0, 3));
      v.rd    = int'($urandom_range(0, 3));
      apply(model(v));
      if ($urandom_range(0, 4) == 0) begin
        mem_rvalid = 1'b1; mem_err = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_rvalid = 1'b0; mem_err = 1'b0;
        chk("idle_stray_rvalid", {lsu_ready, rdata_valid, fault}, 3'b000);
      end
    end

`ifdef RV_LSU_TIMEOUT_EN
    do_reset();
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 64'h40;
    @(negedge clk);
    chk("to_req_c1", t_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_req_held", t_req, 1'b1);
    end
    @(negedge clk);
    chk("to_req_dropped", t_req, 1'b0);
    chk("to_no_ready_yet", t_ready, 1'b0);
    @(negedge clk);
    chk("to_fault", t_fault, 1'b1);
    chk("to_ready", t_ready, 1'b1);
    chk("to_no_rvalid", t_rvalid, 1'b0);
    lsu_valid = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("to_stray_ignored", {t_ready, t_rvalid, t_fault}, 3'b000);
    chk("to_idle_req", t_req, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
